// File: rtl/seed_load_ctrl.sv
// Loads the rho / rho_prime / Kata seeds from a 1024-bit word stream and
// pulses each seed register's write enable once its section is complete.
module seed_load_ctrl #(
  parameter int unsigned WORD_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              Rho_en,
  output logic [255:0]      Rho_din,
  output logic              Rho_prime_en,
  output logic [511:0]      Rho_prime_din,
  output logic              Kata_en,
  output logic [255:0]      Kata_din,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N_RHO  = 256 / WORD_W;
  localparam int unsigned N_RHOP = 512 / WORD_W;
  localparam int unsigned N_TOT  = 1024 / WORD_W;
  localparam int unsigned CNT_W  = $clog2(N_TOT) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RHO  = 3'd1,
    LD_RHOP = 3'd2,
    LD_KATA = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               accept;
  logic               rho_en_d, rhop_en_d, kata_en_d;

  // State and word-counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state, acceptance and section-complete pulse requests.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    in_ready  = 1'b0;
    accept    = 1'b0;
    rho_en_d  = 1'b0;
    rhop_en_d = 1'b0;
    kata_en_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = LD_RHO;
          cnt_d   = '0;
        end
      end
      LD_RHO: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(N_RHO - 1)) begin
            state_d  = LD_RHOP;
            rho_en_d = 1'b1;
          end
        end
      end
      LD_RHOP: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(N_RHO + N_RHOP - 1)) begin
            state_d   = LD_KATA;
            rhop_en_d = 1'b1;
          end
        end
      end
      LD_KATA: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(N_TOT - 1)) begin
            state_d   = FIN;
            kata_en_d = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; each din slice is selected by the counter value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rho_en        <= 1'b0;
      Rho_prime_en  <= 1'b0;
      Kata_en       <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      Rho_din       <= '0;
      Rho_prime_din <= '0;
      Kata_din      <= '0;
    end else begin
      Rho_en       <= rho_en_d;
      Rho_prime_en <= rhop_en_d;
      Kata_en      <= kata_en_d;
      done         <= kata_en_d;
      busy         <= (state_d != IDLE);
      for (int i = 0; i < int'(N_RHO); i++)
        if (accept && cnt == CNT_W'(i))
          Rho_din[WORD_W*i +: WORD_W] <= in_data;
      for (int i = 0; i < int'(N_RHOP); i++)
        if (accept && cnt == CNT_W'(int'(N_RHO) + i))
          Rho_prime_din[WORD_W*i +: WORD_W] <= in_data;
      for (int i = 0; i < int'(N_RHO); i++)
        if (accept && cnt == CNT_W'(int'(N_RHO + N_RHOP) + i))
          Kata_din[WORD_W*i +: WORD_W] <= in_data;
    end
  end

endmodule

// File: tb/tb_seed_load_ctrl.sv
// Self-checking bench for seed_load_ctrl: 64-bit and 256-bit word instances
// checked cycle by cycle against a stream-position model of the seed bank.
module tb_seed_load_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [63:0]  in_data;
  logic         in_ready;
  logic         Rho_en, Rho_prime_en, Kata_en, busy, done;
  logic [255:0] Rho_din, Kata_din;
  logic [511:0] Rho_prime_din;

  logic         b_start, b_valid;
  logic [255:0] b_data;
  logic         b_ready, b_rho_en, b_rhop_en, b_kata_en, b_busy, b_done;
  logic [255:0] b_rho_din, b_kata_din;
  logic [511:0] b_rhop_din;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1023:0] m_bank;

  always #5 clk = ~clk;

  seed_load_ctrl #(.WORD_W(64)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready),
    .Rho_en(Rho_en), .Rho_din(Rho_din),
    .Rho_prime_en(Rho_prime_en), .Rho_prime_din(Rho_prime_din),
    .Kata_en(Kata_en), .Kata_din(Kata_din), .busy(busy), .done(done)
  );

  seed_load_ctrl #(.WORD_W(256)) u_dut_w256 (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid),
    .in_data(b_data), .in_ready(b_ready),
    .Rho_en(b_rho_en), .Rho_din(b_rho_din),
    .Rho_prime_en(b_rhop_en), .Rho_prime_din(b_rhop_din),
    .Kata_en(b_kata_en), .Kata_din(b_kata_din), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] rand_stream();
    logic [1023:0] s;
    for (int i = 0; i < 32; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic chk_bank(input string tag);
    chk({tag, "_rho_din"},  Rho_din,       m_bank[255:0]);
    chk({tag, "_rhop_din"}, Rho_prime_din, m_bank[767:256]);
    chk({tag, "_kata_din"}, Kata_din,      m_bank[1023:768]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},     busy,         1'b0);
    chk({tag, "_ready"},    in_ready,     1'b0);
    chk({tag, "_rho_en"},   Rho_en,       1'b0);
    chk({tag, "_rhop_en"},  Rho_prime_en, 1'b0);
    chk({tag, "_kata_en"},  Kata_en,      1'b0);
    chk({tag, "_done"},     done,         1'b0);
  endtask

  // mode: 0 valid always, 1 valid toggling, 2 random valid.
  // start_at: cycle index of a mid-load start pulse (-1 for none).
  // abort_at: word count at which reset is applied (-1 for none).
  task automatic run_load(input logic [1023:0] stream, input int mode,
                          input int start_at, input int abort_at);
    int acc = 0;
    int cyc = 0;
    bit v, took;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_busy", busy, 1'b1);
    chk("load_ready", in_ready, 1'b1);
    while (acc < 16 && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? stream[64*acc +: 64] : {$urandom, $urandom};
      start    = (cyc == start_at);
      @(posedge clk);
      took = in_valid;
      #1;
      if (took) begin
        m_bank[64*acc +: 64] = stream[64*acc +: 64];
        acc++;
      end
      chk("rho_en",  Rho_en,       took && acc == 4);
      chk("rhop_en", Rho_prime_en, took && acc == 12);
      chk("kata_en", Kata_en,      took && acc == 16);
      chk("done",    done,         took && acc == 16);
      chk("busy",    busy,         1'b1);
      chk("ready",   in_ready,     acc < 16);
      chk_bank("run");
      if (acc == abort_at) begin
        in_valid = 1'b0;
        start    = 1'b0;
        #2 reset = 1'b0;
        #1;
        m_bank = '0;
        chk_quiet("abort");
        chk_bank("abort");
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          chk_quiet("post_abort");
        end
        in_valid = 1'b0;
        return;
      end
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("handshakes", 32'(acc), 32'd16);
    @(posedge clk); #1;
    chk_quiet("after_done");
    chk_bank("after_done");
  endtask

  initial begin
    logic [1023:0] s;
    logic [1023:0] bs;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    m_bank = '0;
    #12;
    chk_quiet("reset");
    chk_bank("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic load with the multiples-of-0x1111... pattern.
    for (int k = 0; k < 16; k++) s[64*k +: 64] = 64'h1111111111111111 * 64'(k + 1);
    run_load(s, 0, -1, -1);
    chk("basic_rho0",  Rho_din[63:0],        64'h1111111111111111);
    chk("basic_rhop0", Rho_prime_din[63:0],  64'h5555555555555555);
    chk("basic_kata3", Kata_din[255:192],    64'h1111111111111110);

    // Throttled source, same data.
    run_load(s, 1, -1, -1);
    // Start pulse mid-load must be ignored.
    run_load(rand_stream(), 2, 5, -1);
    // Reset after word 6, then a clean load.
    run_load(rand_stream(), 0, -1, 7);
    run_load(rand_stream(), 2, -1, -1);
    // Back-to-back loads with distinct data.
    run_load(rand_stream(), 0, -1, -1);
    run_load(rand_stream(), 0, -1, -1);
    run_load(rand_stream(), 2, 9, -1);

    // 256-bit words: one word per section boundary check.
    bs = rand_stream();
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    chk("w256_busy", b_busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      b_valid = 1'b1;
      b_data  = bs[256*k +: 256];
      @(posedge clk); #1;
      chk("w256_rho_en",  b_rho_en,  k == 0);
      chk("w256_rhop_en", b_rhop_en, k == 2);
      chk("w256_kata_en", b_kata_en, k == 3);
      chk("w256_done",    b_done,    k == 3);
      chk("w256_ready",   b_ready,   k < 3);
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    chk("w256_idle_busy", b_busy,   1'b0);
    chk("w256_idle_done", b_done,   1'b0);
    chk("w256_rho_din",  b_rho_din,  bs[255:0]);
    chk("w256_rhop_din", b_rhop_din, bs[767:256]);
    chk("w256_kata_din", b_kata_din, bs[1023:768]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
